sound_state_ctl: RTL and testbench

SOUND_STATE_CTL -- requirements
Module: sound_state_ctl

---
 rtl/sound_state_ctl.sv | 116 +++++++++++
 tb/tb_sound_state_ctl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_state_ctl.sv
// sound_state_ctl -- sound selector FSM for the audio top.
//
// Rising edges on the game-logic levels select what the audio path plays.
// WIN and LOSE play a timed jingle. When the jingle times out the block
// returns to IDLE and pulses done. A new game_start aborts any jingle.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   game_start in   level; rising edge requests the game soundtrack
//   game_win   in   level; rising edge requests the win jingle
//   game_lose  in   level; rising edge requests the lose jingle
//   state[1:0] out  00 IDLE, 01 GAME, 10 WIN, 11 LOSE (registered)
//   busy       out  high while state is WIN or LOSE (registered)
//   done       out  one-cycle pulse after a jingle times out (registered)
module sound_state_ctl #(
    parameter logic [31:0] WIN_CYCLES  = 32'd300000000,
    parameter logic [31:0] LOSE_CYCLES = 32'd400000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_start,
    input  logic       game_win,
    input  logic       game_lose,
    output logic [1:0] state,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GAME = 2'b01,
        ST_WIN  = 2'b10,
        ST_LOSE = 2'b11
    } state_t;

    state_t      cur_state, nxt_state;
    logic [31:0] timer, nxt_timer;
    logic        nxt_busy, nxt_done;
    logic        prev_start, prev_win, prev_lose;
    logic        edge_start, edge_win, edge_lose;

    // The previous-value registers reset high, so a level that is already
    // high when reset is released does not count as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_start <= 1'b1;
            prev_win   <= 1'b1;
            prev_lose  <= 1'b1;
        end else begin
            prev_start <= game_start;
            prev_win   <= game_win;
            prev_lose  <= game_lose;
        end
    end

    assign edge_start = game_start & ~prev_start;
    assign edge_win   = game_win   & ~prev_win;
    assign edge_lose  = game_lose  & ~prev_lose;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_IDLE;
            timer     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            timer     <= nxt_timer;
            busy      <= nxt_busy;
            done      <= nxt_done;
        end
    end

    // The timer is zero outside the jingles. A jingle leaves at
    // CYCLES-1, which is below 2^32-1, so the increment never wraps.
    always_comb begin
        nxt_state = cur_state;
        nxt_timer = '0;
        nxt_done  = 1'b0;
        unique case (cur_state)
            ST_IDLE: begin
                if (edge_start) nxt_state = ST_GAME;
            end
            ST_GAME: begin
                if (edge_lose)     nxt_state = ST_LOSE;
                else if (edge_win) nxt_state = ST_WIN;
            end
            ST_WIN: begin
                if (edge_start) begin
                    nxt_state = ST_GAME;
                end else if (timer == WIN_CYCLES - 32'd1) begin
                    nxt_state = ST_IDLE;
                    nxt_done  = 1'b1;
                end else begin
                    nxt_timer = timer + 32'd1;
                end
            end
            ST_LOSE: begin
                if (edge_start) begin
                    nxt_state = ST_GAME;
                end else if (timer == LOSE_CYCLES - 32'd1) begin
                    nxt_state = ST_IDLE;
                    nxt_done  = 1'b1;
                end else begin
                    nxt_timer = timer + 32'd1;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
        nxt_busy = (nxt_state == ST_WIN) || (nxt_state == ST_LOSE);
    end

    assign state = cur_state;

endmodule

// File: tb/tb_sound_state_ctl.sv
// Directed bench for sound_state_ctl with WIN_CYCLES=8, LOSE_CYCLES=5.
// Inputs change just after a negedge; outputs are sampled on negedges.
module tb_sound_state_ctl;

    logic       clk;
    logic       rst_n;
    logic       game_start;
    logic       game_win;
    logic       game_lose;
    logic [1:0] state;
    logic       busy;
    logic       done;

    int unsigned checks;
    int unsigned failures;

    sound_state_ctl #(
        .WIN_CYCLES (32'd8),
        .LOSE_CYCLES(32'd5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .game_start(game_start),
        .game_win  (game_win),
        .game_lose (game_lose),
        .state     (state),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got t=%0t required finish", $time);
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Clear all inputs, then raise game_start to enter GAME from IDLE.
    task automatic go_game();
        game_start = 1'b0;
        game_win   = 1'b0;
        game_lose  = 1'b0;
        step();
        game_start = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        game_start = 1'b0;
        game_win   = 1'b0;
        game_lose  = 1'b0;
        step();
        step();
        checks++;
        if (state !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got state=%b busy=%b done=%b, required 00 0 0", state, busy, done);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_start();
        game_start = 1'b1;
        checks++;
        if (state !== 2'b00) begin
            failures++;
            $display("FAIL start_before_edge: got state=%b, required 00", state);
        end
        step();
        checks++;
        if (state !== 2'b01 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_to_game: got state=%b busy=%b, required 01 0", state, busy);
        end
    endtask

    task automatic test_win_timeout();
        game_win = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (state !== 2'b10 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL win_hold[%0d]: got state=%b busy=%b done=%b, required 10 1 0", i, state, busy, done);
            end
            step();
        end
        checks++;
        if (state !== 2'b00 || busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL win_timeout: got state=%b busy=%b done=%b, required 00 0 1", state, busy, done);
        end
        step();
        checks++;
        if (state !== 2'b00 || done !== 1'b0) begin
            failures++;
            $display("FAIL win_done_pulse: got state=%b done=%b, required 00 0", state, done);
        end
    endtask

    task automatic test_both_lose();
        go_game();
        game_start = 1'b0;
        game_win   = 1'b1;
        game_lose  = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== 2'b11 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL lose_hold[%0d]: got state=%b busy=%b done=%b, required 11 1 0", i, state, busy, done);
            end
            step();
        end
        checks++;
        if (state !== 2'b00 || busy !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL lose_timeout: got state=%b busy=%b done=%b, required 00 0 1", state, busy, done);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL lose_done_pulse: got done=%b, required 0", done);
        end
    endtask

    task automatic test_abort();
        go_game();
        game_start = 1'b0;
        game_win   = 1'b1;
        step();                              // first WIN cycle, timer=0
        for (int i = 0; i < 3; i++) step();  // timer=3
        game_start = 1'b1;
        step();
        checks++;
        if (state !== 2'b01 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_to_game: got state=%b busy=%b done=%b, required 01 0 0", state, busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (state !== 2'b01 || done !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_done[%0d]: got state=%b done=%b, required 01 0", i, state, done);
            end
            step();
        end
        game_lose = 1'b1;
        step();
        checks++;
        if (state !== 2'b11 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_then_lose: got state=%b busy=%b, required 11 1", state, busy);
        end
    endtask

    task automatic test_timeout_priority();
        go_game();
        game_start = 1'b0;
        game_win   = 1'b1;
        step();                              // timer=0
        for (int i = 0; i < 7; i++) step();  // timer=7, the timeout cycle
        game_start = 1'b1;
        step();
        checks++;
        if (state !== 2'b01 || done !== 1'b0) begin
            failures++;
            $display("FAIL priority_start: got state=%b done=%b, required 01 0", state, done);
        end
        step();
        checks++;
        if (state !== 2'b01 || done !== 1'b0) begin
            failures++;
            $display("FAIL priority_no_done: got state=%b done=%b, required 01 0", state, done);
        end
    endtask

    task automatic test_reset_held();
        rst_n      = 1'b0;
        game_start = 1'b1;
        game_win   = 1'b0;
        game_lose  = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (state !== 2'b00) begin
            failures++;
            $display("FAIL held_start_no_edge: got state=%b, required 00", state);
        end
        game_start = 1'b0;
        step();
        game_start = 1'b1;
        step();
        checks++;
        if (state !== 2'b01) begin
            failures++;
            $display("FAIL held_start_reraise: got state=%b, required 01", state);
        end
    endtask

    task automatic test_reset_mid();
        go_game();
        game_start = 1'b0;
        game_lose  = 1'b1;
        step();
        checks++;
        if (state !== 2'b11) begin
            failures++;
            $display("FAIL mid_enter_lose: got state=%b, required 11", state);
        end
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mid_async_reset: got state=%b busy=%b done=%b, required 00 0 0", state, busy, done);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (state !== 2'b00 || done !== 1'b0) begin
                failures++;
                $display("FAIL mid_after_release[%0d]: got state=%b done=%b, required 00 0", i, state, done);
            end
        end
        game_win = 1'b1;
        step();
        step();
        checks++;
        if (state !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignores_win: got state=%b busy=%b, required 00 0", state, busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_start();
        test_win_timeout();
        test_both_lose();
        test_abort();
        test_timeout_priority();
        test_reset_held();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
